// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, default byte/FIFO sizing and
// the pointer-width helper used by the transmit buffer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int UART_WIDTH = 8;
    localparam int UART_DEPTH = 16;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int UART_PTR_W = ptr_width(UART_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with registered full/empty flags and a sticky overflow flag.
// Full is judged at the start of the cycle: a push while full is always dropped.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = UART_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push_i & full_q);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flags come from the next-state count so they are valid the cycle it lands.
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART: queues host bytes and launches them one
// at a time on DataIN/EN, pacing each launch on the UART's TxReady handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH       = UART_WIDTH,
    parameter int DEPTH       = UART_DEPTH,
    parameter int ACK_TIMEOUT = 16,
    localparam int CNT_W = ptr_width(DEPTH) + 1,
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             WrEN,
    input  logic [WIDTH-1:0] WrData,
    output logic             Full,
    output logic             Empty,
    output logic [CNT_W-1:0] Count,
    output logic             Overflow,
    input  logic             TxReady,
    output logic [WIDTH-1:0] DataIN,
    output logic             EN,
    output tx_state_t        StateDbg
);

    // Handshake: a byte is offered only while TxReady=1 (UART idle). EN is a
    // single-cycle strobe with DataIN valid; the UART acknowledges by dropping
    // TxReady and signals completion by raising it again.

    tx_state_t        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             en_q, en_d;
    logic             pop;
    logic [WIDTH-1:0] head;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .reset_i     (Reset),
        .push_i      (WrEN),
        .push_data_i (WrData),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (Full),
        .empty_o     (Empty),
        .count_o     (Count),
        .overflow_o  (Overflow)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Empty && TxReady) begin
                    pop     = 1'b1;
                    data_d  = head;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A UART that never acknowledges must not stall the queue forever.
                if (!TxReady) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (TxReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        en_d = (state_d == LAUNCH);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign DataIN   = data_q;
    assign EN       = en_q;
    assign StateDbg = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, hand sequences for latency, ordering,
// overflow, timeout and mid-operation reset, then randomized traffic.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int TO = 16;

    logic        clk     = 1'b0;
    logic        Reset   = 1'b1;
    logic        WrEN    = 1'b0;
    logic [W-1:0] WrData = '0;
    logic        TxReady;
    logic        Full, Empty, Overflow, EN;
    logic [4:0]  Count;
    logic [W-1:0] DataIN;
    tx_state_t   StateDbg;

    // UART model controls
    logic tx_manual   = 1'b1;
    logic uart_auto   = 1'b0;
    logic uart_ignore = 1'b0;
    logic auto_rdy    = 1'b1;
    int   busy_len    = 10;
    int   busy        = 0;

    assign TxReady = uart_auto ? auto_rdy : tx_manual;

    uart_tx_fifo #(.WIDTH(W), .DEPTH(D), .ACK_TIMEOUT(TO)) dut (
        .CLK      (clk),
        .Reset    (Reset),
        .WrEN     (WrEN),
        .WrData   (WrData),
        .Full     (Full),
        .Empty    (Empty),
        .Count    (Count),
        .Overflow (Overflow),
        .TxReady  (TxReady),
        .DataIN   (DataIN),
        .EN       (EN),
        .StateDbg (StateDbg)
    );

    always #5 clk = ~clk;

    // Values seen by the DUT at each rising edge
    int          cyc       = 0;
    logic        mon_en    = 1'b0;
    logic        rst_prev  = 1'b0;
    logic        tx_prev   = 1'b0;
    logic        pend_wr   = 1'b0;
    logic [W-1:0] pend_data = '0;

    always @(posedge clk) begin
        cyc++;
        rst_prev  = Reset;
        tx_prev   = TxReady;
        pend_wr   = WrEN && !Reset;
        pend_data = WrData;
        if (Reset) mon_en = 1'b1;
    end

    // Scoreboard: bytes accepted but not yet launched, in write order
    logic [W-1:0] exp_q[$];
    logic         m_ovf    = 1'b0;
    logic         en_prev  = 1'b0;
    logic [W-1:0] last_din = '0;
    int           en_cnt   = 0;
    int           en_cyc   = 0;
    int           n_checks = 0;
    int           n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (!mon_en) return;
        if (rst_prev) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else if (pend_wr) begin
            if (exp_q.size() == D) m_ovf = 1'b1;
            else exp_q.push_back(pend_data);
        end
        if (EN === 1'b1) begin
            en_cnt++;
            en_cyc = cyc;
            check("en_single", 32'(en_prev), 32'd0);
            check("en_pace", 32'(tx_prev), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL en_unexpected: got launch of %0h, required no launch (cycle %0d)", DataIN, cyc);
            end else begin
                check("en_data", 32'(DataIN), 32'(exp_q.pop_front()));
            end
        end
        check("count", 32'(Count), 32'(exp_q.size()));
        check("empty", 32'(Empty), 32'(exp_q.size() == 0));
        check("full", 32'(Full), 32'(exp_q.size() == D));
        check("overflow", 32'(Overflow), 32'(m_ovf));
        if (rst_prev) check("datain_rst", 32'(DataIN), 32'd0);
        else if (EN !== 1'b1) check("datain_hold", 32'(DataIN), 32'(last_din));
        last_din = DataIN;
        en_prev  = EN;
    endtask

    task automatic uart_model();
        if (!uart_auto) begin
            auto_rdy = 1'b1;
            busy     = 0;
        end else if (EN === 1'b1 && !uart_ignore) begin
            auto_rdy = 1'b0;
            busy     = busy_len;
        end else if (!auto_rdy) begin
            if (busy <= 1) auto_rdy = 1'b1;
            else busy--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        uart_model();
    endtask

    task automatic wr_byte(input logic [W-1:0] d);
        WrEN   = 1'b1;
        WrData = d;
        tick();
        WrEN   = 1'b0;
    endtask

    task automatic wait_en_to(input int target, input int budget, input string name);
        for (int k = 0; k < budget && en_cnt < target; k++) tick();
        check(name, 32'(en_cnt), 32'(target));
    endtask

    typedef struct {
        logic         wr;
        logic [W-1:0] d;
        logic         txr;
        logic [4:0]   cnt;
        logic         en;
        logic [W-1:0] din;
        tx_state_t    st;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int base;
        int t0;
        vecs[0]  = '{1'b1, 8'hEA, 1'b1, 5'd1, 1'b0, 8'h00, IDLE};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'hEA, LAUNCH};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hEA, WAIT_BUSY};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hEA, WAIT_DONE};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hEA, WAIT_DONE};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hEA, IDLE};
        vecs[6]  = '{1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 8'hEA, IDLE};
        vecs[7]  = '{1'b1, 8'h3D, 1'b1, 5'd1, 1'b1, 8'h3C, LAUNCH};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 8'h3C, WAIT_BUSY};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h3C, WAIT_DONE};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 8'h3C, IDLE};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h3D, LAUNCH};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h3D, WAIT_BUSY};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h3D, WAIT_DONE};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h3D, IDLE};

        // Reset state
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_en", 32'(EN), 32'd0);
        check("rst_datain", 32'(DataIN), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        check("rst_state", 32'(StateDbg), 32'(IDLE));

        // Vector table
        for (int i = 0; i < 15; i++) begin
            WrEN      = vecs[i].wr;
            WrData    = vecs[i].d;
            tx_manual = vecs[i].txr;
            tick();
            check($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_en", i), 32'(EN), 32'(vecs[i].en));
            check($sformatf("vec%0d_datain", i), 32'(DataIN), 32'(vecs[i].din));
            check($sformatf("vec%0d_state", i), 32'(StateDbg), 32'(vecs[i].st));
        end
        WrEN = 1'b0;
        tx_manual = 1'b1;

        // Single byte: two-cycle write-to-EN latency, UART busy 10 cycles
        uart_auto = 1'b1;
        busy_len  = 10;
        tick();
        WrEN = 1'b1;
        WrData = 8'hEA;
        tick();
        WrEN = 1'b0;
        check("lat_n1_en", 32'(EN), 32'd0);
        check("lat_n1_empty", 32'(Empty), 32'd0);
        tick();
        check("lat_n2_en", 32'(EN), 32'd1);
        check("lat_n2_datain", 32'(DataIN), 32'hEA);
        repeat (14) tick();
        check("single_idle", 32'(StateDbg), 32'(IDLE));
        check("single_empty", 32'(Empty), 32'd1);

        // Ordering and pacing, UART busy 20 cycles per byte
        busy_len = 20;
        base = en_cnt;
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        wait_en_to(base + 5, 200, "order_launches");
        check("order_drained", 32'(exp_q.size()), 32'd0);

        // Sustained writes while draining: pointers wrap, push and pop overlap
        busy_len = 2;
        base = en_cnt;
        for (int i = 0; i < 40; i++) begin
            wr_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(3, 6)) tick();
        end
        wait_en_to(base + 40, 300, "wrap_launches");
        check("wrap_no_overflow", 32'(Overflow), 32'd0);

        // Full and overflow with the UART held busy
        repeat (6) tick();
        uart_auto = 1'b0;
        tx_manual = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            wr_byte(8'(8'h10 + i));
            if (i == 14) check("full_at15", 32'(Full), 32'd0);
            if (i == 15) check("full_at16", 32'(Full), 32'd1);
        end
        check("ovf_full", 32'(Full), 32'd1);
        check("ovf_count", 32'(Count), 32'd16);
        check("ovf_flag", 32'(Overflow), 32'd1);
        check("ovf_exp_q", 32'(exp_q.size()), 32'd16);
        uart_auto = 1'b1;
        busy_len  = 3;
        base = en_cnt;
        wait_en_to(base + 16, 300, "ovf_drain");
        repeat (10) tick();
        check("ovf_drain_empty", 32'(Empty), 32'd1);
        check("ovf_sticky", 32'(Overflow), 32'd1);

        // Ack timeout: UART never drops TxReady
        uart_ignore = 1'b1;
        base = en_cnt;
        wr_byte(8'hA0);
        wr_byte(8'hA1);
        wait_en_to(base + 1, 10, "to_first");
        t0 = en_cyc;
        wait_en_to(base + 2, 40, "to_second");
        check("to_gap", 32'(en_cyc - t0), 32'(TO + 2));
        repeat (TO + 4) tick();
        check("to_idle", 32'(StateDbg), 32'(IDLE));
        uart_ignore = 1'b0;

        // Reset during WAIT_DONE with bytes queued
        uart_auto = 1'b0;
        tx_manual = 1'b1;
        base = en_cnt;
        wr_byte(8'hB0);
        wait_en_to(base + 1, 10, "mr_launch");
        tx_manual = 1'b0;
        for (int i = 1; i <= 4; i++) wr_byte(8'(8'hB0 + i));
        check("mr_state", 32'(StateDbg), 32'(WAIT_DONE));
        check("mr_count_before", 32'(Count), 32'd4);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mr_count", 32'(Count), 32'd0);
        check("mr_en", 32'(EN), 32'd0);
        check("mr_state_idle", 32'(StateDbg), 32'(IDLE));
        base = en_cnt;
        tx_manual = 1'b1;
        repeat (30) tick();
        check("mr_no_launch", 32'(en_cnt), 32'(base));
        check("mr_overflow_clr", 32'(Overflow), 32'd0);

        // Randomized traffic with random UART frame times
        uart_auto = 1'b1;
        for (int i = 0; i < 500; i++) begin
            busy_len = $urandom_range(1, 8);
            WrEN     = ($urandom_range(0, 99) < 35);
            WrData   = 8'($urandom_range(0, 255));
            tick();
        end
        WrEN = 1'b0;
        for (int k = 0; k < 600 && exp_q.size() != 0; k++) tick();
        repeat (15) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_idle", 32'(StateDbg), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
